// File: rtl/qpu_exu_alu_dpath_arb_if.sv
// rtl/qpu_exu_alu_dpath_arb_if.sv - request/response and datapath bundle for the ALU datapath arbiter
interface qpu_exu_alu_dpath_arb_if #(
  parameter int XLEN = 32
);
  logic            r0_req_valid;
  logic            r0_req_ready;
  logic [3:0]      r0_req_op;
  logic [XLEN-1:0] r0_req_op1;
  logic [XLEN-1:0] r0_req_op2;
  logic            r0_rsp_valid;
  logic            r0_rsp_ready;

  logic            r1_req_valid;
  logic            r1_req_ready;
  logic [3:0]      r1_req_op;
  logic [XLEN-1:0] r1_req_op1;
  logic [XLEN-1:0] r1_req_op2;
  logic            r1_rsp_valid;
  logic            r1_rsp_ready;

  logic [XLEN-1:0] rsp_res;
  logic            dp_add;
  logic            dp_xor;
  logic            dp_or;
  logic            dp_and;
  logic [XLEN-1:0] dp_op1;
  logic [XLEN-1:0] dp_op2;
  logic [XLEN-1:0] dp_res;
  logic            err_multi_op;

  modport slave (
    input  r0_req_valid, r0_req_op, r0_req_op1, r0_req_op2, r0_rsp_ready,
    input  r1_req_valid, r1_req_op, r1_req_op1, r1_req_op2, r1_rsp_ready,
    input  dp_res,
    output r0_req_ready, r0_rsp_valid, r1_req_ready, r1_rsp_valid,
    output rsp_res, dp_add, dp_xor, dp_or, dp_and, dp_op1, dp_op2,
    output err_multi_op
  );

  modport master (
    output r0_req_valid, r0_req_op, r0_req_op1, r0_req_op2, r0_rsp_ready,
    output r1_req_valid, r1_req_op, r1_req_op1, r1_req_op2, r1_rsp_ready,
    output dp_res,
    input  r0_req_ready, r0_rsp_valid, r1_req_ready, r1_rsp_valid,
    input  rsp_res, dp_add, dp_xor, dp_or, dp_and, dp_op1, dp_op2,
    input  err_multi_op
  );
endinterface

// File: rtl/qpu_exu_alu_dpath_arb.sv
// rtl/qpu_exu_alu_dpath_arb.sv - round-robin arbiter and one-entry result buffer for the shared ALU datapath
module qpu_exu_alu_dpath_arb #(
  parameter int XLEN    = 32,
  parameter bit RR_INIT = 1'b0
) (
  input logic                     clk,
  input logic                     rst,
  qpu_exu_alu_dpath_arb_if.slave  bus
);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            rr_q, rr_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] res_q, res_d;

  logic            any_valid;
  logic            winner;
  logic            rsp_fire;
  logic            can_accept;
  logic            accept;
  logic [3:0]      win_op;
  logic [3:0]      dp_sel;
  logic [XLEN-1:0] win_op1;
  logic [XLEN-1:0] win_op2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      rr_q    <= RR_INIT;
      err_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    any_valid = bus.r0_req_valid | bus.r1_req_valid;
    winner    = (bus.r0_req_valid && bus.r1_req_valid) ? rr_q : bus.r1_req_valid;
    win_op    = winner ? bus.r1_req_op  : bus.r0_req_op;
    win_op1   = winner ? bus.r1_req_op1 : bus.r0_req_op1;
    win_op2   = winner ? bus.r1_req_op2 : bus.r0_req_op2;

    // add > xor > or > and; an empty op word executes as add
    dp_sel = 4'b0000;
    if (any_valid) begin
      if (win_op[0] || win_op == 4'b0000) dp_sel = 4'b0001;
      else if (win_op[1])                 dp_sel = 4'b0010;
      else if (win_op[2])                 dp_sel = 4'b0100;
      else                                dp_sel = 4'b1000;
    end

    rsp_fire   = (state_q == HOLD) && (owner_q ? bus.r1_rsp_ready : bus.r0_rsp_ready);
    can_accept = !rst && ((state_q == IDLE) || rsp_fire);
    accept     = can_accept && any_valid;

    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    err_d   = err_q;
    res_d   = res_q;
    if (accept) begin
      state_d = HOLD;
      owner_d = winner;
      rr_d    = ~winner;
      res_d   = bus.dp_res;
      err_d   = err_q | ((win_op & (win_op - 4'd1)) != 4'd0);
    end else if (rsp_fire) begin
      state_d = IDLE;
    end
  end

  assign bus.r0_req_ready = accept && !winner;
  assign bus.r1_req_ready = accept &&  winner;
  assign bus.r0_rsp_valid = !rst && (state_q == HOLD) && !owner_q;
  assign bus.r1_rsp_valid = !rst && (state_q == HOLD) &&  owner_q;
  assign bus.rsp_res      = res_q;
  assign bus.err_multi_op = err_q;
  assign bus.dp_add       = dp_sel[0];
  assign bus.dp_xor       = dp_sel[1];
  assign bus.dp_or        = dp_sel[2];
  assign bus.dp_and       = dp_sel[3];
  assign bus.dp_op1       = any_valid ? win_op1 : '0;
  assign bus.dp_op2       = any_valid ? win_op2 : '0;

endmodule

// File: tb/tb_qpu_exu_alu_dpath_arb.sv
// tb/tb_qpu_exu_alu_dpath_arb.sv - directed bench with a transaction-level model of the arbiter
module tb_qpu_exu_alu_dpath_arb;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  qpu_exu_alu_dpath_arb_if #(.XLEN(XLEN)) bus ();

  qpu_exu_alu_dpath_arb #(.XLEN(XLEN), .RR_INIT(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // shared datapath: one-hot flags pick the operation
  assign bus.dp_res = bus.dp_add ? bus.dp_op1 + bus.dp_op2 :
                      bus.dp_xor ? bus.dp_op1 ^ bus.dp_op2 :
                      bus.dp_or  ? bus.dp_op1 | bus.dp_op2 :
                      bus.dp_and ? bus.dp_op1 & bus.dp_op2 : '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] alu(input logic [3:0] op, input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
    if (op[0] || op == 4'd0) return a + b;
    if (op[1])               return a ^ b;
    if (op[2])               return a | b;
    return a & b;
  endfunction

  function automatic logic [3:0] onehot_of(input logic [3:0] op);
    for (int i = 0; i < 4; i++) if (op[i]) return 4'b0001 << i;
    return 4'b0001;
  endfunction

  // model state: buffer contents, owner, priority pointer, sticky error
  bit              m_full = 0, m_owner = 0, m_rr = 0, m_err = 0;
  logic [XLEN-1:0] m_res = '0;
  bit              n_full, n_owner, n_rr, n_err;
  logic [XLEN-1:0] n_res;

  always @(negedge clk) begin
    bit w, any, fire, acc;
    logic [3:0] op;
    logic [XLEN-1:0] a, b;
    if (rst) begin
      chk("rst_r0_req_ready", bus.r0_req_ready, 0);
      chk("rst_r1_req_ready", bus.r1_req_ready, 0);
      chk("rst_r0_rsp_valid", bus.r0_rsp_valid, 0);
      chk("rst_r1_rsp_valid", bus.r1_rsp_valid, 0);
      n_full = 0; n_owner = 0; n_rr = 0; n_err = 0; n_res = '0;
    end else begin
      any  = bus.r0_req_valid || bus.r1_req_valid;
      w    = (bus.r0_req_valid && bus.r1_req_valid) ? m_rr : bus.r1_req_valid;
      fire = m_full && (m_owner ? bus.r1_rsp_ready : bus.r0_rsp_ready);
      acc  = (!m_full || fire) && any;
      op   = w ? bus.r1_req_op  : bus.r0_req_op;
      a    = w ? bus.r1_req_op1 : bus.r0_req_op1;
      b    = w ? bus.r1_req_op2 : bus.r0_req_op2;
      chk("m_r0_req_ready", bus.r0_req_ready, acc && !w);
      chk("m_r1_req_ready", bus.r1_req_ready, acc && w);
      chk("m_r0_rsp_valid", bus.r0_rsp_valid, m_full && !m_owner);
      chk("m_r1_rsp_valid", bus.r1_rsp_valid, m_full && m_owner);
      chk("m_rsp_res", bus.rsp_res, m_res);
      chk("m_err_multi_op", bus.err_multi_op, m_err);
      chk("m_dp_flags", {bus.dp_and, bus.dp_or, bus.dp_xor, bus.dp_add}, any ? onehot_of(op) : 4'd0);
      chk("m_dp_op1", bus.dp_op1, any ? a : '0);
      chk("m_dp_op2", bus.dp_op2, any ? b : '0);
      n_full = m_full; n_owner = m_owner; n_rr = m_rr; n_err = m_err; n_res = m_res;
      if (acc) begin
        n_full = 1; n_owner = w; n_rr = !w; n_res = alu(op, a, b);
        n_err = m_err || ($countones(op) > 1);
      end else if (fire) begin
        n_full = 0;
      end
    end
  end

  always @(posedge clk) begin
    m_full = n_full; m_owner = n_owner; m_rr = n_rr; m_err = n_err; m_res = n_res;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.r0_req_valid = 0; bus.r0_req_op = 0; bus.r0_req_op1 = 0; bus.r0_req_op2 = 0;
    bus.r1_req_valid = 0; bus.r1_req_op = 0; bus.r1_req_op1 = 0; bus.r1_req_op2 = 0;
    bus.r0_rsp_ready = 0; bus.r1_rsp_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    tick();
    tick();
    rst = 0;
  endtask

  task automatic req0(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    bus.r0_req_valid = 1; bus.r0_req_op = op; bus.r0_req_op1 = a; bus.r0_req_op2 = b;
  endtask

  task automatic req1(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    bus.r1_req_valid = 1; bus.r1_req_op = op; bus.r1_req_op1 = a; bus.r1_req_op2 = b;
  endtask

  initial begin
    idle_inputs();
    do_reset();
    #1;
    chk("reset_rsp_res", bus.rsp_res, 0);
    chk("reset_err", bus.err_multi_op, 0);
    chk("reset_r0_rsp_valid", bus.r0_rsp_valid, 0);

    // r0 alone: 5 + 7
    req0(4'b0001, 5, 7);
    bus.r0_rsp_ready = 1;
    #1 chk("t1_r0_req_ready", bus.r0_req_ready, 1);
    tick();
    bus.r0_req_valid = 0;
    #1;
    chk("t1_r0_rsp_valid", bus.r0_rsp_valid, 1);
    chk("t1_r1_rsp_valid", bus.r1_rsp_valid, 0);
    chk("t1_rsp_res", bus.rsp_res, 12);
    tick();

    // both valid every cycle: grants alternate starting with r0
    do_reset();
    req0(4'b0010, 32'hF0, 32'hFF);
    req1(4'b0100, 32'h01, 32'h10);
    bus.r0_rsp_ready = 1; bus.r1_rsp_ready = 1;
    for (int k = 0; k < 4; k++) begin
      logic [XLEN-1:0] exp_res;
      #1;
      chk("t2_r0_grant", bus.r0_req_ready, (k % 2) == 0);
      chk("t2_r1_grant", bus.r1_req_ready, (k % 2) == 1);
      if (k > 0) begin
        exp_res = (k % 2 == 1) ? 32'h0F : 32'h11;
        chk("t2_rsp_res", bus.rsp_res, exp_res);
      end
      tick();
    end
    idle_inputs();
    bus.r0_rsp_ready = 1; bus.r1_rsp_ready = 1;
    tick();

    // r1 result held for 3 cycles stalls r0
    bus.r0_rsp_ready = 0; bus.r1_rsp_ready = 0;
    req1(4'b0100, 32'h01, 32'h10);
    #1 chk("t3_r1_req_ready", bus.r1_req_ready, 1);
    tick();
    bus.r1_req_valid = 0;
    req0(4'b0001, 5, 7);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_r0_stall", bus.r0_req_ready, 0);
      chk("t3_res_stable", bus.rsp_res, 32'h11);
      tick();
    end
    bus.r1_rsp_ready = 1;
    #1 chk("t3_r0_accept", bus.r0_req_ready, 1);
    tick();
    bus.r0_req_valid = 0; bus.r1_rsp_ready = 0;
    #1;
    chk("t3_r0_rsp_valid", bus.r0_rsp_valid, 1);
    chk("t3_rsp_res", bus.rsp_res, 12);
    bus.r0_rsp_ready = 1;
    tick();

    // multi-bit op executes as add and sets the sticky error
    req0(4'b0011, 3, 1);
    #1;
    chk("t4_dp_add", bus.dp_add, 1);
    chk("t4_dp_xor", bus.dp_xor, 0);
    tick();
    bus.r0_req_valid = 0;
    #1;
    chk("t4_rsp_res", bus.rsp_res, 4);
    chk("t4_err", bus.err_multi_op, 1);
    tick();

    // and, then empty op as add
    req0(4'b1000, 32'hFFFF0000, 32'h0F0F0F0F);
    tick();
    bus.r0_req_valid = 0;
    #1 chk("t5_and_res", bus.rsp_res, 32'h0F0F0000);
    tick();
    req0(4'b0000, 2, 2);
    tick();
    bus.r0_req_valid = 0;
    #1;
    chk("t5_zero_op_res", bus.rsp_res, 4);
    chk("t5_err_sticky", bus.err_multi_op, 1);
    tick();

    // reset with a result pending
    bus.r0_rsp_ready = 0;
    req1(4'b0001, 9, 9);
    tick();
    bus.r1_req_valid = 0;
    #1 chk("t6_pending", bus.r1_rsp_valid, 1);
    do_reset();
    #1;
    chk("t6_r0_rsp_valid", bus.r0_rsp_valid, 0);
    chk("t6_r1_rsp_valid", bus.r1_rsp_valid, 0);
    chk("t6_rsp_res", bus.rsp_res, 0);
    chk("t6_err_cleared", bus.err_multi_op, 0);
    req0(4'b0001, 1, 1);
    req1(4'b0001, 2, 2);
    #1;
    chk("t6_r0_first", bus.r0_req_ready, 1);
    chk("t6_r1_loses", bus.r1_req_ready, 0);
    tick();
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
